// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - RV32I next-PC generator with branch evaluation, trap and stall-buffered redirect
//
// Purpose:
//   Holds the program counter and picks the next fetch address each cycle.
//   Jump targets are chosen in priority order: JALR, then JAL, then a taken
//   conditional branch, then the sequential PC+4.
//   A non-sequential target that is not word aligned is not followed. The PC
//   goes to TRAP_VECTOR and the sticky misaligned flag is set.
//   A redirect requested while the pipeline is stalled is held in a
//   one-entry buffer. It is applied on the first cycle without a stall.
//
// Ports:
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   stall        in   hold the PC this cycle
//   branch       in   conditional branch instruction
//   jump         in   JAL
//   jalr         in   JALR
//   funct3       in   branch condition code
//   zero/lt/ltu  in   ALU flags (equal, signed less, unsigned less)
//   imm          in   sign-extended, pre-shifted offset
//   jalr_base    in   rs1 value for JALR
//   pc           out  current PC (registered)
//   pc_plus4     out  pc + 4 (combinational)
//   redirect     out  one-cycle pulse when pc first shows a non-sequential value
//   misaligned   out  sticky misaligned-target trap flag
//   taken_count  out  saturating count of applied redirects (traps included)

module next_pc_unit #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned       CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              branch,
  input  logic              jump,
  input  logic              jalr,
  input  logic [2:0]        funct3,
  input  logic              zero,
  input  logic              lt,
  input  logic              ltu,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   jalr_base,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              redirect,
  output logic              misaligned,
  output logic [CNT_W-1:0]  taken_count
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } state_t;

  state_t           r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_redirect;
  logic             r_misaligned;
  logic [CNT_W-1:0] r_taken_count;
  logic [XLEN-1:0]  r_pend_target;
  logic             r_pend_trap;

  logic             w_cond;
  logic             w_req;
  logic             w_trap;
  logic [XLEN-1:0]  w_seq;
  logic [XLEN-1:0]  w_jalr_sum;
  logic [XLEN-1:0]  w_jalr_target;
  logic [XLEN-1:0]  w_rel_target;
  logic [XLEN-1:0]  w_target;
  logic [CNT_W-1:0] w_count_inc;

  // Branch condition decode. The reserved codes 010/011 never take.
  always_comb begin
    w_cond = 1'b0;
    unique case (funct3)
      3'b000:  w_cond = zero;
      3'b001:  w_cond = ~zero;
      3'b100:  w_cond = lt;
      3'b101:  w_cond = ~lt;
      3'b110:  w_cond = ltu;
      3'b111:  w_cond = ~ltu;
      default: w_cond = 1'b0;
    endcase
  end

  // All sums are modulo 2^XLEN. A carry out of the top bit is dropped on purpose.
  assign w_seq         = r_pc + XLEN'(4);
  assign w_jalr_sum    = jalr_base + imm;
  assign w_jalr_target = {w_jalr_sum[XLEN-1:1], 1'b0};
  assign w_rel_target  = r_pc + imm;

  // JAL and a taken branch share the PC-relative adder. JALR outranks both.
  assign w_req    = jalr | jump | (branch & w_cond);
  assign w_target = jalr ? w_jalr_target : w_rel_target;

  // Clearing bit 0 of a JALR target cannot fix bit 1. A word-misaligned
  // JALR therefore still traps.
  assign w_trap   = w_req & (w_target[1:0] != 2'b00);

  // The counter holds at all-ones rather than wrapping.
  assign w_count_inc = (r_taken_count == {CNT_W{1'b1}}) ? r_taken_count
                                                        : r_taken_count + CNT_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_VECTOR;
      r_redirect    <= 1'b0;
      r_misaligned  <= 1'b0;
      r_taken_count <= '0;
      r_pend_target <= '0;
      r_pend_trap   <= 1'b0;
    end else begin
      // Cycles that apply a redirect re-assert this below. All other cycles,
      // including stalls, leave it low.
      r_redirect <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (!stall) begin
            if (w_req) begin
              r_pc          <= w_trap ? TRAP_VECTOR : w_target;
              r_redirect    <= 1'b1;
              r_taken_count <= w_count_inc;
              if (w_trap) begin
                r_misaligned <= 1'b1;
              end
            end else begin
              r_pc <= w_seq;
            end
          end else if (w_req) begin
            // Keep the resolved target and its trap verdict. The PC adder
            // inputs may have changed by the time the stall lifts.
            r_pend_target <= w_target;
            r_pend_trap   <= w_trap;
            r_state       <= S_PENDING;
          end
        end

        S_PENDING: begin
          // The buffered redirect is applied once. Requests that arrive while
          // it waits, and the inputs on the release cycle, are dropped.
          if (!stall) begin
            r_pc          <= r_pend_trap ? TRAP_VECTOR : r_pend_target;
            r_redirect    <= 1'b1;
            r_taken_count <= w_count_inc;
            if (r_pend_trap) begin
              r_misaligned <= 1'b1;
            end
            r_pend_trap   <= 1'b0;
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign pc_plus4    = w_seq;
  assign redirect    = r_redirect;
  assign misaligned  = r_misaligned;
  assign taken_count = r_taken_count;

endmodule
